// File: rtl/pl_pc_seq_pkg.sv
// Shared definitions for the pc sequencer: FSM states, mcause values and
// exception codes used by the IF-stage pc logic and the CSR write port.
package pl_defs;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_TRAP  = 2'd3
    } seq_state_e;

    localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;

    localparam logic [3:0] EXC_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] EXC_ILLEGAL_INSTR  = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
    localparam logic [3:0] EXC_ECALL_M        = 4'd11;

    // Synchronous exceptions carry a clear interrupt bit in mcause.
    function automatic logic [31:0] exc_mcause(input logic [3:0] code);
        return {28'd0, code};
    endfunction

endpackage

// File: rtl/pl_pc_seq_if.sv
// Pipeline <-> pc sequencer bundle: redirect/trap sources in, npc and the
// mepc/mcause write port out.
interface pl_pc_seq_if;
    logic [31:0] pc;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_tgt;
    logic        exc;
    logic [31:0] exc_pc;
    logic [3:0]  exc_cause;
    logic        mret;
    logic [31:0] mepc_in;
    logic [31:0] mtvec;
    logic        irq;
    logic        fpu_busy;
    logic [31:0] npc;
    logic        wpc;
    logic        fetch_kill;
    logic        epc_we;
    logic [31:0] epc_out;
    logic [31:0] cause_out;
    logic        irq_ack;

    modport master (
        output pc, stall, redirect, redirect_tgt, exc, exc_pc, exc_cause,
               mret, mepc_in, mtvec, irq, fpu_busy,
        input  npc, wpc, fetch_kill, epc_we, epc_out, cause_out, irq_ack
    );

    modport slave (
        input  pc, stall, redirect, redirect_tgt, exc, exc_pc, exc_cause,
               mret, mepc_in, mtvec, irq, fpu_busy,
        output npc, wpc, fetch_kill, epc_we, epc_out, cause_out, irq_ack
    );
endinterface

// File: rtl/pl_pc_drain_cnt.sv
// Saturating drain counter: counts killed-fetch cycles ahead of an interrupt
// trap and flags when the pipeline behind IF is empty.
module pl_pc_drain_cnt #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CW           = 3
) (
    input  logic clk,
    input  logic clrn,
    input  logic clr,
    input  logic inc,
    output logic done
);

    logic [CW-1:0] cnt_r;
    logic          done_s;

    assign done_s = (cnt_r == CW'(DRAIN_CYCLES));
    assign done   = done_s;

    // Count register: clear wins over increment, holds once saturated.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (inc && !done_s) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/pl_pc_seq.sv
// Program-counter sequencer: picks npc/wpc each cycle among sequential fetch,
// stall, redirect, exception, mret and a precisely drained external interrupt.
module pl_pc_seq
    import pl_defs::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 4,
    parameter int          CW           = 3
) (
    input  logic         clk,
    input  logic         clrn,
    pl_pc_seq_if.slave   bus
);

    seq_state_e  state_r;
    seq_state_e  state_nxt_s;
    logic        cnt_clr_s;
    logic        cnt_inc_s;
    logic        drain_done_s;
    logic [31:0] pc_inc_s;
    logic [31:0] npc_s;
    logic        wpc_s;
    logic        kill_s;
    logic        epc_we_s;
    logic [31:0] epc_out_s;
    logic [31:0] cause_out_s;
    logic        irq_ack_s;

    assign pc_inc_s = bus.pc + 32'd4;

    pl_pc_drain_cnt #(
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .CW           (CW)
    ) u_drain_cnt (
        .clk  (clk),
        .clrn (clrn),
        .clr  (cnt_clr_s),
        .inc  (cnt_inc_s),
        .done (drain_done_s)
    );

    // State register; reset restarts fetch from RESET_PC via BOOT.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and pc/CSR-port outputs.
    always_comb begin
        state_nxt_s = state_r;
        npc_s       = pc_inc_s;
        wpc_s       = 1'b1;
        kill_s      = 1'b0;
        epc_we_s    = 1'b0;
        epc_out_s   = 32'd0;
        cause_out_s = 32'd0;
        irq_ack_s   = 1'b0;
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        case (state_r)
            ST_BOOT: begin
                npc_s       = RESET_PC;
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (bus.exc) begin
                    npc_s       = bus.mtvec;
                    kill_s      = 1'b1;
                    epc_we_s    = 1'b1;
                    epc_out_s   = bus.exc_pc;
                    cause_out_s = exc_mcause(bus.exc_cause);
                end else if (bus.mret) begin
                    npc_s  = bus.mepc_in;
                    kill_s = 1'b1;
                end else if (bus.redirect) begin
                    npc_s  = bus.redirect_tgt;
                    kill_s = 1'b1;
                end else if (bus.irq && !bus.stall) begin
                    wpc_s       = 1'b0;
                    kill_s      = 1'b1;
                    cnt_clr_s   = 1'b1;
                    state_nxt_s = ST_DRAIN;
                end else if (bus.stall) begin
                    wpc_s = 1'b0;
                end else begin
                    npc_s = pc_inc_s;
                end
            end
            ST_DRAIN: begin
                kill_s    = 1'b1;
                cnt_inc_s = 1'b1;
                if (bus.exc) begin
                    npc_s       = bus.mtvec;
                    epc_we_s    = 1'b1;
                    epc_out_s   = bus.exc_pc;
                    cause_out_s = exc_mcause(bus.exc_cause);
                    state_nxt_s = ST_RUN;
                end else begin
                    // An older branch still resolving in EX must land even
                    // while fetch is held; mret here is younger and dropped.
                    wpc_s = bus.redirect;
                    if (bus.redirect) begin
                        npc_s = bus.redirect_tgt;
                    end else begin
                        npc_s = pc_inc_s;
                    end
                    if (!bus.irq) begin
                        state_nxt_s = ST_RUN;
                    end else if (drain_done_s && !bus.fpu_busy && !bus.redirect) begin
                        state_nxt_s = ST_TRAP;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
            end
            ST_TRAP: begin
                npc_s       = bus.mtvec;
                kill_s      = 1'b1;
                epc_we_s    = 1'b1;
                epc_out_s   = bus.pc;
                cause_out_s = MCAUSE_MEI;
                irq_ack_s   = 1'b1;
                state_nxt_s = ST_RUN;
            end
            default: begin
                npc_s       = RESET_PC;
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    assign bus.npc        = npc_s;
    assign bus.wpc        = wpc_s;
    assign bus.fetch_kill = kill_s;
    assign bus.epc_we     = epc_we_s;
    assign bus.epc_out    = epc_out_s;
    assign bus.cause_out  = cause_out_s;
    assign bus.irq_ack    = irq_ack_s;

endmodule
